// File: rtl/imem_fetch_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : imem_fetch_arbiter                                          |
// | Description : Single-port instruction memory sequencer shared between    |
// |               the core fetch stage (valid/ready request and response)    |
// |               and the program loader (32-bit word writes). Registers     |
// |               fetch responses and classifies misaligned / out-of-range   |
// |               fetches into one-shot exceptions.                          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                     |
// |   clk, rst_n          clock, synchronous active-low reset                 |
// |   flush               drop the outstanding fetch response (redirect)      |
// |   fetch_req_*         fetch request: valid/ready handshake, byte PC       |
// |   fetch_rsp_*         registered response: valid/ready, instruction word, |
// |                       exception enable, code and value (faulting PC)      |
// |   ld_valid/ld_ready   loader write handshake                              |
// |   ld_addr/ld_data     loader byte address and write data                  |
// |   ld_err              one-cycle pulse after a rejected loader write       |
// |   mem_addr/mem_we/    array port, driven combinationally from the         |
// |   mem_wdata/mem_rdata granted requester; mem_rdata is combinational      |
// +--------------------------------------------------------------------------+

module imem_fetch_arbiter #(
   parameter int unsigned XLEN         = 64,
   parameter int unsigned MEM_SIZE     = 2048,
   parameter int unsigned LD_BURST_MAX = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   // fetch request
   input  logic            fetch_req_valid,
   output logic            fetch_req_ready,
   input  logic [XLEN-1:0] fetch_req_pc,
   // fetch response
   output logic            fetch_rsp_valid,
   input  logic            fetch_rsp_ready,
   output logic [31:0]     fetch_rsp_instr,
   output logic            fetch_rsp_exc_en,
   output logic [3:0]      fetch_rsp_exc_code,
   output logic [XLEN-1:0] fetch_rsp_exc_val,
   // program loader
   input  logic            ld_valid,
   output logic            ld_ready,
   input  logic [XLEN-1:0] ld_addr,
   input  logic [31:0]     ld_data,
   output logic            ld_err,
   // instruction array port
   output logic [XLEN-1:0] mem_addr,
   input  logic [31:0]     mem_rdata,
   output logic            mem_we,
   output logic [31:0]     mem_wdata
);

   // ------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------
   localparam logic [31:0]       c_nop_instr        = 32'h0000_0013;
   localparam logic [3:0]        c_exc_misaligned   = 4'd0;
   localparam logic [3:0]        c_exc_access_fault = 4'd1;
   localparam int unsigned       c_cnt_w            = $clog2(LD_BURST_MAX + 1);
   localparam logic [c_cnt_w-1:0] c_burst_limit     = c_cnt_w'(LD_BURST_MAX);
   localparam logic [XLEN-1:0]   c_mem_words        = XLEN'(MEM_SIZE);

   localparam logic [0:0] c_st_idle = 1'b0;
   localparam logic [0:0] c_st_resp = 1'b1;

   // An address is in range when its full word index (all upper bits, not
   // just the bits that address the array) is below the array depth.
   function automatic logic f_in_range(input logic [XLEN-3:0] word_addr);
      return ({2'b00, word_addr} < c_mem_words);
   endfunction

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [0:0]         state_q,          state_d;
   logic [c_cnt_w-1:0] burst_cnt_q,      burst_cnt_d;
   logic               rsp_valid_q,      rsp_valid_d;
   logic [31:0]        rsp_instr_q,      rsp_instr_d;
   logic               rsp_exc_en_q,     rsp_exc_en_d;
   logic [3:0]         rsp_exc_code_q,   rsp_exc_code_d;
   logic [XLEN-1:0]    rsp_exc_val_q,    rsp_exc_val_d;
   logic               ld_err_q,         ld_err_d;

   // ------------------------------------------------------------------
   // Arbitration
   // ------------------------------------------------------------------
   logic w_fetch_elig;
   logic w_ld_elig;
   logic w_burst_full;
   logic w_grant_ld;
   logic w_grant_fetch;
   logic w_ld_ok;
   logic w_mem_we;

   always_comb begin
      // Fetch can only be taken when the response register is free and no
      // redirect is in progress; nothing is granted while held in reset.
      w_fetch_elig  = rst_n && (state_q == c_st_idle) && fetch_req_valid && !flush;
      w_ld_elig     = rst_n && ld_valid;
      w_burst_full  = (burst_cnt_q == c_burst_limit);

      // Loader has priority until it has used up its burst allowance while
      // a fetch is waiting; then the fetch gets one slot.
      w_grant_ld    = w_ld_elig && !(w_fetch_elig && w_burst_full);
      w_grant_fetch = w_fetch_elig && !(w_ld_elig && !w_burst_full);

      w_ld_ok       = f_in_range(ld_addr[XLEN-1:2]) && (ld_addr[1:0] == 2'b00);
      w_mem_we      = w_grant_ld && w_ld_ok;
   end

   // ------------------------------------------------------------------
   // Array port
   // ------------------------------------------------------------------
   always_comb begin
      mem_addr = '0;
      if (w_grant_ld) begin
         mem_addr = ld_addr;
      end else if (w_grant_fetch) begin
         mem_addr = fetch_req_pc;
      end
   end

   assign mem_we          = w_mem_we;
   assign mem_wdata       = w_mem_we ? ld_data : 32'h0;
   assign ld_ready        = w_grant_ld;
   assign fetch_req_ready = w_grant_fetch;

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d        = state_q;
      rsp_valid_d    = rsp_valid_q;
      rsp_instr_d    = rsp_instr_q;
      rsp_exc_en_d   = rsp_exc_en_q;
      rsp_exc_code_d = rsp_exc_code_q;
      rsp_exc_val_d  = rsp_exc_val_q;

      // A rejected write is reported one cycle after it was accepted.
      ld_err_d = w_grant_ld && !w_ld_ok;

      // The burst counter only measures loader grants that made a pending
      // fetch wait. It saturates because grants taken while a response is
      // held (where fetch cannot win anyway) would otherwise overflow it.
      if (!fetch_req_valid || w_grant_fetch) begin
         burst_cnt_d = '0;
      end else if (w_grant_ld && !w_burst_full) begin
         burst_cnt_d = burst_cnt_q + c_cnt_w'(1);
      end else begin
         burst_cnt_d = burst_cnt_q;
      end

      case (state_q)
         c_st_idle: begin
            if (w_grant_fetch) begin
               state_d     = c_st_resp;
               rsp_valid_d = 1'b1;
               // Misalignment outranks the range check.
               if (fetch_req_pc[1:0] != 2'b00) begin
                  rsp_instr_d    = c_nop_instr;
                  rsp_exc_en_d   = 1'b1;
                  rsp_exc_code_d = c_exc_misaligned;
                  rsp_exc_val_d  = fetch_req_pc;
               end else if (!f_in_range(fetch_req_pc[XLEN-1:2])) begin
                  rsp_instr_d    = c_nop_instr;
                  rsp_exc_en_d   = 1'b1;
                  rsp_exc_code_d = c_exc_access_fault;
                  rsp_exc_val_d  = fetch_req_pc;
               end else begin
                  rsp_instr_d    = mem_rdata;
                  rsp_exc_en_d   = 1'b0;
                  rsp_exc_code_d = 4'd0;
                  rsp_exc_val_d  = '0;
               end
            end else if (flush) begin
               rsp_valid_d  = 1'b0;
               rsp_exc_en_d = 1'b0;
            end
         end
         c_st_resp: begin
            // Handshake and flush both retire the response; clearing the
            // exception flag here is what makes it one-shot.
            if (flush || fetch_rsp_ready) begin
               state_d      = c_st_idle;
               rsp_valid_d  = 1'b0;
               rsp_exc_en_d = 1'b0;
            end
         end
         default: begin
            state_d      = c_st_idle;
            rsp_valid_d  = 1'b0;
            rsp_exc_en_d = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= c_st_idle;
         burst_cnt_q    <= '0;
         rsp_valid_q    <= 1'b0;
         rsp_instr_q    <= c_nop_instr;
         rsp_exc_en_q   <= 1'b0;
         rsp_exc_code_q <= 4'd0;
         rsp_exc_val_q  <= '0;
         ld_err_q       <= 1'b0;
      end else begin
         state_q        <= state_d;
         burst_cnt_q    <= burst_cnt_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_instr_q    <= rsp_instr_d;
         rsp_exc_en_q   <= rsp_exc_en_d;
         rsp_exc_code_q <= rsp_exc_code_d;
         rsp_exc_val_q  <= rsp_exc_val_d;
         ld_err_q       <= ld_err_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign fetch_rsp_valid    = rsp_valid_q;
   assign fetch_rsp_instr    = rsp_instr_q;
   assign fetch_rsp_exc_en   = rsp_exc_en_q;
   assign fetch_rsp_exc_code = rsp_exc_code_q;
   assign fetch_rsp_exc_val  = rsp_exc_val_q;
   assign ld_err             = ld_err_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_fetch_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_imem_fetch_arbiter                                      |
// | Description : Self-checking bench for imem_fetch_arbiter. A behavioural  |
// |               model predicts grants and responses every cycle; directed  |
// |               sequences add literal expectations at key points.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+

module tb_imem_fetch_arbiter;

   localparam int XLEN         = 64;
   localparam int MEM_SIZE     = 2048;
   localparam int LD_BURST_MAX = 4;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic            clk;
   logic            rst_n;
   logic            flush;
   logic            fetch_req_valid;
   logic            fetch_req_ready;
   logic [XLEN-1:0] fetch_req_pc;
   logic            fetch_rsp_valid;
   logic            fetch_rsp_ready;
   logic [31:0]     fetch_rsp_instr;
   logic            fetch_rsp_exc_en;
   logic [3:0]      fetch_rsp_exc_code;
   logic [XLEN-1:0] fetch_rsp_exc_val;
   logic            ld_valid;
   logic            ld_ready;
   logic [XLEN-1:0] ld_addr;
   logic [31:0]     ld_data;
   logic            ld_err;
   logic [XLEN-1:0] mem_addr;
   logic [31:0]     mem_rdata;
   logic            mem_we;
   logic [31:0]     mem_wdata;

   int n_checks = 0;
   int n_fail   = 0;

   imem_fetch_arbiter #(
      .XLEN         (XLEN),
      .MEM_SIZE     (MEM_SIZE),
      .LD_BURST_MAX (LD_BURST_MAX)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .flush              (flush),
      .fetch_req_valid    (fetch_req_valid),
      .fetch_req_ready    (fetch_req_ready),
      .fetch_req_pc       (fetch_req_pc),
      .fetch_rsp_valid    (fetch_rsp_valid),
      .fetch_rsp_ready    (fetch_rsp_ready),
      .fetch_rsp_instr    (fetch_rsp_instr),
      .fetch_rsp_exc_en   (fetch_rsp_exc_en),
      .fetch_rsp_exc_code (fetch_rsp_exc_code),
      .fetch_rsp_exc_val  (fetch_rsp_exc_val),
      .ld_valid           (ld_valid),
      .ld_ready           (ld_ready),
      .ld_addr            (ld_addr),
      .ld_data            (ld_data),
      .ld_err             (ld_err),
      .mem_addr           (mem_addr),
      .mem_rdata          (mem_rdata),
      .mem_we             (mem_we),
      .mem_wdata          (mem_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction array attached to the DUT port.
   logic [31:0] tb_mem [0:MEM_SIZE-1];
   assign mem_rdata = ((mem_addr >> 2) < 64'(MEM_SIZE)) ? tb_mem[mem_addr[12:2]] : 32'h0;
   always @(posedge clk) begin
      if (mem_we) tb_mem[mem_addr[12:2]] <= mem_wdata;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Behavioural model and per-cycle compare
   // ------------------------------------------------------------------
   logic            m_pending;     // a response is being held for the core
   logic [31:0]     m_instr;
   logic            m_exc;
   logic [3:0]      m_code;
   logic [63:0]     m_val;
   logic            m_ld_err;
   int              m_burst;
   logic [31:0]     exp_mem [0:MEM_SIZE-1];

   initial begin : model
      logic fetch_wants, ld_wants, take_ld, take_fetch, ld_good, exp_we;
      m_pending = 1'b0; m_instr = NOP; m_exc = 1'b0; m_code = 4'd0;
      m_val = 64'd0; m_ld_err = 1'b0; m_burst = 0;
      forever begin
         @(negedge clk);
         #2;
         fetch_wants = rst_n && !m_pending && fetch_req_valid && !flush;
         ld_wants    = rst_n && ld_valid;
         take_ld     = ld_wants && !(fetch_wants && (m_burst == LD_BURST_MAX));
         take_fetch  = fetch_wants && !take_ld;
         ld_good     = ((ld_addr >> 2) < 64'(MEM_SIZE)) && (ld_addr % 4 == 0);
         exp_we      = take_ld && ld_good;

         chk("fetch_req_ready", fetch_req_ready, take_fetch);
         chk("ld_ready", ld_ready, take_ld);
         chk("mem_we", mem_we, exp_we);
         if (take_ld)    chk("mem_addr_ld", mem_addr, ld_addr);
         if (take_fetch) chk("mem_addr_fetch", mem_addr, fetch_req_pc);
         if (exp_we)     chk("mem_wdata", mem_wdata, ld_data);
         chk("ld_err", ld_err, m_ld_err);
         chk("rsp_valid", fetch_rsp_valid, m_pending);
         chk("rsp_exc_en", fetch_rsp_exc_en, m_exc);
         if (m_pending) begin
            chk("rsp_instr", fetch_rsp_instr, m_instr);
            chk("rsp_exc_code", fetch_rsp_exc_code, m_code);
            chk("rsp_exc_val", fetch_rsp_exc_val, m_val);
         end

         // advance to the state after the coming clock edge
         if (!rst_n) begin
            m_pending = 1'b0; m_instr = NOP; m_exc = 1'b0; m_code = 4'd0;
            m_val = 64'd0; m_ld_err = 1'b0; m_burst = 0;
         end else begin
            if (exp_we) exp_mem[ld_addr[12:2]] = ld_data;
            m_ld_err = take_ld && !ld_good;
            if (!fetch_req_valid || take_fetch) m_burst = 0;
            else if (take_ld && m_burst < LD_BURST_MAX) m_burst++;
            if (take_fetch) begin
               m_pending = 1'b1;
               if (fetch_req_pc % 4 != 0) begin
                  m_instr = NOP; m_exc = 1'b1; m_code = 4'd0; m_val = fetch_req_pc;
               end else if ((fetch_req_pc >> 2) >= 64'(MEM_SIZE)) begin
                  m_instr = NOP; m_exc = 1'b1; m_code = 4'd1; m_val = fetch_req_pc;
               end else begin
                  m_instr = exp_mem[fetch_req_pc[12:2]]; m_exc = 1'b0;
                  m_code = 4'd0; m_val = 64'd0;
               end
            end else if (flush || (m_pending && fetch_rsp_ready)) begin
               m_pending = 1'b0;
               m_exc     = 1'b0;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Directed stimulus with literal expectations
   // ------------------------------------------------------------------
   task automatic ld_write(input logic [63:0] a, input logic [31:0] d);
      @(negedge clk);
      ld_valid = 1'b1; ld_addr = a; ld_data = d;
      #1;
      chk("lit_ld_write_we", mem_we, 1'b1);
      @(negedge clk);
      ld_valid = 1'b0;
   endtask

   task automatic ld_bad(input logic [63:0] a);
      @(negedge clk);
      ld_valid = 1'b1; ld_addr = a; ld_data = 32'hDEAD_BEEF;
      #1;
      chk("lit_ld_bad_ready", ld_ready, 1'b1);
      chk("lit_ld_bad_we", mem_we, 1'b0);
      @(negedge clk);
      ld_valid = 1'b0;
      #1;
      chk("lit_ld_err_pulse", ld_err, 1'b1);
      @(negedge clk);
      #1;
      chk("lit_ld_err_clear", ld_err, 1'b0);
   endtask

   task automatic fetch_lit(input logic [63:0] pc, input logic [31:0] e_instr,
                            input logic e_exc, input logic [3:0] e_code,
                            input logic [63:0] e_val);
      @(negedge clk);
      fetch_req_valid = 1'b1; fetch_req_pc = pc;
      #1;
      chk("lit_req_ready", fetch_req_ready, 1'b1);
      @(negedge clk);
      fetch_req_valid = 1'b0;
      #1;
      chk("lit_rsp_valid", fetch_rsp_valid, 1'b1);
      chk("lit_rsp_instr", fetch_rsp_instr, e_instr);
      chk("lit_rsp_exc_en", fetch_rsp_exc_en, e_exc);
      chk("lit_rsp_exc_code", fetch_rsp_exc_code, e_code);
      chk("lit_rsp_exc_val", fetch_rsp_exc_val, e_val);
      fetch_rsp_ready = 1'b1;
      @(negedge clk);
      fetch_rsp_ready = 1'b0;
      #1;
      chk("lit_rsp_retired", fetch_rsp_valid, 1'b0);
      chk("lit_exc_one_shot", fetch_rsp_exc_en, 1'b0);
   endtask

   function automatic logic [63:0] pick_addr();
      logic [63:0] w;
      w = 64'($urandom_range(0, 15)) << 2;
      case ($urandom_range(0, 5))
         0, 1, 2: return w;
         3:       return w | 64'($urandom_range(1, 3));
         4:       return 64'h2000 + w;
         default: return 64'h8000_0000_0000_0000 | w;
      endcase
   endfunction

   initial begin : driver
      int n_we;
      logic got_f;
      logic adv;
      rst_n = 1'b0; flush = 1'b0; fetch_req_valid = 1'b0; fetch_req_pc = '0;
      fetch_rsp_ready = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("lit_reset_rsp_valid", fetch_rsp_valid, 1'b0);
      chk("lit_reset_instr", fetch_rsp_instr, NOP);
      chk("lit_reset_exc_en", fetch_rsp_exc_en, 1'b0);
      chk("lit_reset_ld_err", ld_err, 1'b0);
      chk("lit_reset_mem_we", mem_we, 1'b0);

      // preload words 0..15
      for (int i = 0; i < 16; i++) begin
         if (i == 0)      ld_write(64'h0, 32'h1111_1111);
         else if (i == 5) ld_write(64'h14, 32'h0050_0093);
         else             ld_write(64'(i) << 2, 32'hC0DE_0000 + 32'(i));
      end

      fetch_lit(64'h14,   32'h0050_0093, 1'b0, 4'd0, 64'h0);
      fetch_lit(64'h2000, NOP,           1'b1, 4'd1, 64'h2000);
      fetch_lit(64'h6,    NOP,           1'b1, 4'd0, 64'h6);

      // loader and fetch both continuously valid
      @(negedge clk);
      ld_valid = 1'b1; ld_addr = 64'h40; ld_data = 32'hA000_0000;
      fetch_req_valid = 1'b1; fetch_req_pc = 64'h0;
      n_we = 0; got_f = 1'b0;
      for (int i = 0; i < 10 && !got_f; i++) begin
         #1;
         adv = ld_ready;
         if (fetch_req_ready) got_f = 1'b1;
         else if (mem_we) n_we++;
         @(negedge clk);
         if (got_f) fetch_req_valid = 1'b0;
         if (adv) begin ld_addr = ld_addr + 64'd4; ld_data = ld_data + 32'd1; end
      end
      chk("lit_burst_fetch_granted", got_f, 1'b1);
      chk("lit_burst_we_count", 64'(n_we), 64'd4);
      ld_valid = 1'b0;
      #1;
      chk("lit_burst_rsp_instr", fetch_rsp_instr, 32'h1111_1111);
      fetch_rsp_ready = 1'b1;
      @(negedge clk);
      fetch_rsp_ready = 1'b0;

      // rejected writes leave the array untouched
      ld_bad(64'h8002);
      ld_bad(64'h16);
      fetch_lit(64'h14, 32'h0050_0093, 1'b0, 4'd0, 64'h0);

      // hold the response, then flush it away
      @(negedge clk);
      fetch_req_valid = 1'b1; fetch_req_pc = 64'h0;
      @(negedge clk);
      fetch_req_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("lit_hold_valid", fetch_rsp_valid, 1'b1);
         chk("lit_hold_instr", fetch_rsp_instr, 32'h1111_1111);
         @(negedge clk);
      end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1;
      chk("lit_flush_clears_valid", fetch_rsp_valid, 1'b0);

      // flush outranks a fetch request in IDLE
      @(negedge clk);
      fetch_req_valid = 1'b1; fetch_req_pc = 64'h14; flush = 1'b1;
      #1;
      chk("lit_flush_blocks_req", fetch_req_ready, 1'b0);
      @(negedge clk);
      flush = 1'b0;
      #1;
      chk("lit_req_after_flush", fetch_req_ready, 1'b1);
      @(negedge clk);
      fetch_req_valid = 1'b0;
      fetch_rsp_ready = 1'b1;
      @(negedge clk);
      fetch_rsp_ready = 1'b0;

      // reset in the middle of a held exception response
      @(negedge clk);
      fetch_req_valid = 1'b1; fetch_req_pc = 64'h6;
      @(negedge clk);
      fetch_req_valid = 1'b0;
      #1;
      chk("lit_pre_reset_exc", fetch_rsp_exc_en, 1'b1);
      rst_n = 1'b0; ld_valid = 1'b1; ld_addr = 64'h20; ld_data = 32'h5555_AAAA;
      #1;
      chk("lit_reset_no_we", mem_we, 1'b0);
      chk("lit_reset_no_ld_ready", ld_ready, 1'b0);
      @(negedge clk);
      rst_n = 1'b1; ld_valid = 1'b0;
      #1;
      chk("lit_rst_resp_valid", fetch_rsp_valid, 1'b0);
      chk("lit_rst_resp_exc", fetch_rsp_exc_en, 1'b0);
      chk("lit_rst_resp_instr", fetch_rsp_instr, NOP);
      chk("lit_rst_resp_code", fetch_rsp_exc_code, 4'd0);
      chk("lit_rst_resp_val", fetch_rsp_exc_val, 64'h0);

      // mixed traffic, checked by the model alone
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         fetch_req_valid = ($urandom_range(0, 3) != 0);
         fetch_req_pc    = pick_addr();
         fetch_rsp_ready = 1'($urandom_range(0, 1));
         flush           = ($urandom_range(0, 9) == 0);
         ld_valid        = ($urandom_range(0, 2) == 0);
         ld_addr         = pick_addr();
         ld_data         = $urandom;
      end

      @(negedge clk);
      fetch_req_valid = 1'b0; fetch_rsp_ready = 1'b0; flush = 1'b0; ld_valid = 1'b0;
      repeat (3) @(negedge clk);
      #3;
      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/imem_fetch_arbiter.md
Name: imem_fetch_arbiter

Overview:
- Sequences all accesses to the instruction memory array and shares its single port between two requesters:
  - the core fetch stage, which reads over a valid/ready request/response handshake;
  - the program loader, which writes 32-bit words.
- Registers fetch responses and classifies faults (misaligned, out-of-range) so the core receives an instruction word or a one-shot exception, never both.
- Sits between the fetch stage/loader and the instruction array.

Parameters:
- XLEN, 64, width of PC and exception value.
- MEM_SIZE, 2048, number of 32-bit words in the instruction array.
- LD_BURST_MAX, 4, maximum consecutive loader grants while a fetch is pending.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- flush  input  1  discard the outstanding fetch response (redirect).
- fetch_req_valid  input  1  fetch request present.
- fetch_req_ready  output  1  request accepted this cycle when both valid and ready are high.
- fetch_req_pc  input  XLEN  fetch byte address.
- fetch_rsp_valid  output  1  response held.
- fetch_rsp_ready  input  1  consumer accepts the response.
- fetch_rsp_instr  output  32  instruction word (NOP 0x00000013 on fault).
- fetch_rsp_exc_en  output  1  response is an exception.
- fetch_rsp_exc_code  output  4  0 = instruction address misaligned, 1 = instruction access fault.
- fetch_rsp_exc_val  output  XLEN  faulting PC (mtval).
- ld_valid  input  1  loader write request.
- ld_ready  output  1  write accepted this cycle.
- ld_addr  input  XLEN  loader byte address.
- ld_data  input  32  loader write data.
- ld_err  output  1  one-cycle pulse when an accepted write was out of range or misaligned.
- mem_addr  output  XLEN  array address, driven combinationally from the granted requester.
- mem_rdata  input  32  combinational read data for mem_addr.
- mem_we  output  1  array write enable.
- mem_wdata  output  32  array write data.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - State returns to IDLE.
  - All response outputs go to 0; fetch_rsp_instr goes to 0x00000013.
  - ld_err=0, mem_we=0, burst counter=0.
  - Any in-flight response is dropped, including one reset mid-handshake.
- States:
  - IDLE: port free.
  - RESP: response registered, waiting for fetch_rsp_ready.
- Range check (used for both fetch and load):
  - An address is in range iff addr[XLEN-1:2] < MEM_SIZE.
  - The word index is addr[2+log2(MEM_SIZE)-1:2].
- Arbitration in IDLE:
  - Both requesters idle: no grant.
  - One requester valid: grant it.
  - Both valid: the loader wins unless burst counter == LD_BURST_MAX, in which case the fetch wins.
  - The burst counter increments on each loader grant while fetch_req_valid=1 and clears on a fetch grant or when fetch_req_valid=0.
- Loader grant (single cycle, no state change):
  - ld_ready=1 and mem_addr=ld_addr.
  - In range and ld_addr[1:0]==0: mem_we=1, mem_wdata=ld_data.
  - Otherwise: mem_we=0 and ld_err pulses 1 on the next cycle.
- Fetch grant:
  - fetch_req_ready=1, mem_addr=fetch_req_pc, then go to RESP next cycle.
  - The response register captures, by priority:
    1. pc[1:0]!=0: instr=NOP, exc_en=1, code=0, val=pc.
    2. Out of range: instr=NOP, exc_en=1, code=1, val=pc.
    3. Otherwise: instr=mem_rdata, exc_en=0, code=0, val=0.
  - Latency: request accepted in cycle N, fetch_rsp_valid=1 from cycle N+1.
- RESP:
  - Outputs are held stable while fetch_rsp_ready=0.
  - fetch_req_ready=0; the loader may still be granted, since the response is already captured.
  - fetch_rsp_ready=1: return to IDLE next cycle. Back-to-back fetches therefore take 2 cycles each.
- Exception one-shot:
  - Each faulting request yields exactly one response with exc_en=1.
  - exc_en never stays asserted across two handshakes without a new request.
- Flush:
  - Forces IDLE next cycle and clears fetch_rsp_valid/exc_en.
  - In IDLE with fetch_req_valid=1, flush has priority and the request is not accepted that cycle.
- Simultaneous fetch_rsp_ready and flush: treated as flush; no difference in next state.
- fetch_rsp_valid never depends combinationally on fetch_rsp_ready.

Test Plan:
- After reset, preload word 5 = 0x00500093; fetch pc=0x14 -> one cycle later rsp_valid=1, instr=0x00500093, exc_en=0.
- Fetch pc=0x2000 (word 2048, MEM_SIZE=2048) -> instr=0x00000013, exc_en=1, code=1, val=0x2000; one handshake only, next IDLE cycle exc_en=0.
- Fetch pc=0x6 -> exc_en=1, code=0, val=0x6.
- Loader and fetch both continuously valid -> grant pattern L,L,L,L,F; mem_we high exactly 4 times before fetch_req_ready=1.
- Loader write to ld_addr=0x8002 -> mem_we=0, ld_err=1 for one cycle, array unchanged.
- Hold rsp_ready=0 for 3 cycles, then assert flush -> outputs stable for 3 cycles, then rsp_valid=0 next cycle. Assert rst_n=0 during RESP -> all outputs at reset values next edge.
